// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall detection,
// bubble insertion on hazards and flushes, and a stall counter.
module id_ex_hazard_stage #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_D,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rd_D,
  input  logic [9:0]       ctrl_D,
  input  logic [127:0]     data_D,
  input  logic             flush_E,
  output logic             valid_E,
  output logic [4:0]       rs1_E,
  output logic [4:0]       rs2_E,
  output logic [4:0]       rd_E,
  output logic [9:0]       ctrl_E,
  output logic [127:0]     data_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [2:0] REM_INIT = 3'(LU_STALL - 1);

  state_e       state_q, state_d;
  logic [2:0]   remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         valid_q, valid_d;
  logic [4:0]   rs1_q, rs1_d;
  logic [4:0]   rs2_q, rs2_d;
  logic [4:0]   rd_q, rd_d;
  logic [9:0]   ctrl_q, ctrl_d;
  logic [127:0] data_q, data_d;

  logic hz;
  logic stall;
  logic bubble;

  // Load in EX whose non-x0 destination feeds the ID instruction
  assign hz = valid_q & ctrl_q[8] & valid_D & (rd_q != 5'd0)
            & ((rd_q == rs1_D) | (rd_q == rs2_D));

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    unique case (state_q)
      RUN: begin
        remain_d = 3'd0;
        if (flush_E) begin
          bubble = 1'b1;
        end else if (hz) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (LU_STALL > 1) begin
            state_d  = HOLD;
            remain_d = REM_INIT;
          end
        end
      end
      HOLD: begin
        bubble = 1'b1;
        if (flush_E) begin
          state_d  = RUN;
          remain_d = 3'd0;
        end else begin
          stall    = 1'b1;
          remain_d = remain_q - 3'd1;
          if (remain_q == 3'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d  = RUN;
        remain_d = 3'd0;
        bubble   = 1'b1;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !flush_E && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_D;
    rs1_d   = rs1_D;
    rs2_d   = rs2_D;
    rd_d    = rd_D;
    ctrl_d  = ctrl_D;
    data_d  = data_D;
    if (bubble) begin
      valid_d = 1'b0;
      rs1_d   = 5'd0;
      rs2_d   = 5'd0;
      rd_d    = 5'd0;
      ctrl_d  = 10'd0;
      data_d  = 128'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      remain_q <= 3'd0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
      ctrl_q   <= 10'd0;
      data_q   <= 128'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
    end
  end

  assign valid_E   = valid_q;
  assign rs1_E     = rs1_q;
  assign rs2_E     = rs2_q;
  assign rd_E      = rd_q;
  assign ctrl_E    = ctrl_q;
  assign data_E    = data_q;
  assign stall_F   = stall;
  assign stall_D   = stall;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: instance a has LU_STALL=1,
// instance b has LU_STALL=3 with a 2-bit counter to reach saturation.
module tb_id_ex_hazard_stage;

  localparam logic [9:0] LW  = 10'h300;
  localparam logic [9:0] ADD = 10'h200;
  localparam logic [127:0] DAT = 128'h0000_1000_0000_0004_1111_2222_3333_4444;

  logic clk = 1'b0;
  logic rst;
  logic valid_D;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic [9:0] ctrl_D;
  logic [127:0] data_D;
  logic flush_E;

  logic a_valid, b_valid;
  logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic [9:0] a_ctrl, b_ctrl;
  logic [127:0] a_data, b_data;
  logic a_sf, a_sd, b_sf, b_sd;
  logic [15:0] a_cnt;
  logic [1:0] b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.LU_STALL(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .valid_D(valid_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .ctrl_D(ctrl_D), .data_D(data_D), .flush_E(flush_E),
    .valid_E(a_valid), .rs1_E(a_rs1), .rs2_E(a_rs2),
    .rd_E(a_rd), .ctrl_E(a_ctrl), .data_E(a_data),
    .stall_F(a_sf), .stall_D(a_sd), .stall_cnt(a_cnt)
  );

  id_ex_hazard_stage #(.LU_STALL(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .valid_D(valid_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .ctrl_D(ctrl_D), .data_D(data_D), .flush_E(flush_E),
    .valid_E(b_valid), .rs1_E(b_rs1), .rs2_E(b_rs2),
    .rd_E(b_rd), .ctrl_E(b_ctrl), .data_E(b_data),
    .stall_F(b_sf), .stall_D(b_sd), .stall_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d,
                        input logic [9:0] c);
    valid_D = v;
    rs1_D   = s1;
    rs2_D   = s2;
    rd_D    = d;
    ctrl_D  = c;
    data_D  = DAT ^ {123'd0, d};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush_E = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 10'd0);
    #12;
    chk("rst_valid", 128'(a_valid), 128'd0);
    chk("rst_cnt", 128'(a_cnt), 128'd0);
    rst = 1'b0;

    // Reset mid-stream clears a live EX instruction
    set_id(1'b1, 5'd1, 5'd2, 5'd7, ADD);
    tick();
    chk("cap_valid", 128'(a_valid), 128'd1);
    chk("cap_rd", 128'(a_rd), 128'd7);
    chk("cap_data", a_data, DAT ^ 128'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(a_valid), 128'd0);
    chk("arst_rd", 128'(a_rd), 128'd0);
    chk("arst_ctrl", 128'(a_ctrl), 128'd0);
    chk("arst_data", a_data, 128'd0);
    chk("arst_cnt", 128'(a_cnt), 128'd0);
    chk("arst_stall", 128'(a_sd), 128'd0);
    #1 rst = 1'b0;

    // Load-use with LU_STALL=1
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd6, ADD);
    #1;
    chk("lu1_stallF", 128'(a_sf), 128'd1);
    chk("lu1_stallD", 128'(a_sd), 128'd1);
    tick();
    chk("lu1_bub_valid", 128'(a_valid), 128'd0);
    chk("lu1_bub_rd", 128'(a_rd), 128'd0);
    chk("lu1_stall_off", 128'(a_sd), 128'd0);
    tick();
    chk("lu1_add_rs1", 128'(a_rs1), 128'd5);
    chk("lu1_add_rd", 128'(a_rd), 128'd6);
    chk("lu1_cnt", 128'(a_cnt), 128'd1);

    // Load-use with LU_STALL=3
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd6, ADD);
    #1;
    chk("lu3_s1", 128'(b_sd), 128'd1);
    tick();
    chk("lu3_s2", 128'(b_sf), 128'd1);
    chk("lu3_bub1", 128'(b_valid), 128'd0);
    tick();
    chk("lu3_s3", 128'(b_sd), 128'd1);
    chk("lu3_bub2", 128'(b_rd), 128'd0);
    tick();
    chk("lu3_s_off", 128'(b_sd), 128'd0);
    chk("lu3_bub3", 128'(b_valid), 128'd0);
    chk("lu3_cnt", 128'(b_cnt), 128'd3);
    tick();
    chk("lu3_add_rd", 128'(b_rd), 128'd6);
    chk("lu3_add_rs1", 128'(b_rs1), 128'd5);

    // Second hazard: 2-bit counter must hold at 3
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd6, ADD);
    repeat (4) tick();
    chk("sat_b_cnt", 128'(b_cnt), 128'd3);
    chk("sat_b_rd", 128'(b_rd), 128'd6);
    chk("a_cnt_2", 128'(a_cnt), 128'd2);

    // No-hazard cases
    set_id(1'b1, 5'd1, 5'd0, 5'd0, LW);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd6, ADD);
    #1;
    chk("nh_x0_a", 128'(a_sd), 128'd0);
    chk("nh_x0_b", 128'(b_sd), 128'd0);
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd7, 5'd8, 5'd6, ADD);
    #1;
    chk("nh_indep", 128'(a_sf), 128'd0);
    set_id(1'b1, 5'd1, 5'd0, 5'd5, ADD);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, ADD);
    #1;
    chk("nh_alu", 128'(a_sd), 128'd0);
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b0, 5'd5, 5'd5, 5'd6, ADD);
    #1;
    chk("nh_invalid", 128'(b_sd), 128'd0);
    tick();
    chk("inv_valid", 128'(a_valid), 128'd0);
    chk("inv_rd", 128'(a_rd), 128'd6);
    chk("a_cnt_held", 128'(a_cnt), 128'd2);

    // Flush kills the ID instruction
    set_id(1'b1, 5'd1, 5'd2, 5'd9, ADD);
    flush_E = 1'b1;
    tick();
    chk("fl_valid", 128'(a_valid), 128'd0);
    chk("fl_rd", 128'(a_rd), 128'd0);
    chk("fl_ctrl", 128'(a_ctrl), 128'd0);
    flush_E = 1'b0;

    // Flush together with a hazard: flush wins
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd6, ADD);
    flush_E = 1'b1;
    #1;
    chk("flhz_a", 128'(a_sd), 128'd0);
    chk("flhz_b", 128'(b_sf), 128'd0);
    tick();
    flush_E = 1'b0;
    #1;
    chk("flhz_bub", 128'(b_valid), 128'd0);
    chk("flhz_run", 128'(b_sd), 128'd0);
    chk("flhz_cnt", 128'(a_cnt), 128'd2);

    // Flush while in HOLD returns to RUN
    set_id(1'b1, 5'd1, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd6, ADD);
    tick();
    chk("hold_in", 128'(b_sd), 128'd1);
    flush_E = 1'b1;
    #1;
    chk("hold_fl", 128'(b_sd), 128'd0);
    tick();
    flush_E = 1'b0;
    #1;
    chk("hold_run", 128'(b_sd), 128'd0);
    tick();
    chk("hold_cap", 128'(b_rd), 128'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
